// File: rtl/regfile_serial_pkg.sv
// Shared encodings for the serial register file: rs1 shift views and sequencer states.
package regfile_serial_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SLL    = 2'b01;
  localparam logic [1:0] MODE_SRL    = 2'b10;
  localparam logic [1:0] MODE_SRA    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_bit_select.sv
// Combinational pick of one bit of a shifted view of word at position index.
// Index arithmetic carries one extra bit so out-of-range positions are detected, never wrapped.
module serial_bit_select
  import regfile_serial_pkg::*;
#(
  parameter  int REG_WIDTH = 8,
  localparam int IDX_W     = $clog2(REG_WIDTH)
) (
  input  logic [REG_WIDTH-1:0] word,
  input  logic [IDX_W-1:0]     index,
  input  logic [IDX_W-1:0]     shamt,
  input  logic [1:0]           mode,
  output logic                 sel_bit
);

  logic [IDX_W:0] up;
  logic [IDX_W:0] down;

  assign up   = {1'b0, index} + {1'b0, shamt};
  // A borrow out of the subtraction means index < shamt.
  assign down = {1'b0, index} - {1'b0, shamt};

  always_comb begin
    sel_bit = 1'b0;
    case (mode)
      MODE_DIRECT: sel_bit = word[index];
      MODE_SLL:    sel_bit = down[IDX_W] ? 1'b0 : word[down[IDX_W-1:0]];
      MODE_SRL:    sel_bit = up[IDX_W]   ? 1'b0 : word[up[IDX_W-1:0]];
      MODE_SRA:    sel_bit = up[IDX_W]   ? word[REG_WIDTH-1] : word[up[IDX_W-1:0]];
      default:     sel_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/regfile_serial_multi.sv
// Serial-access register file: two bit-serial read ports, atomic end-of-op write-back,
// parallel port for accumulator/debug. done follows the last serial bit by one cycle.
module regfile_serial_multi
  import regfile_serial_pkg::*;
#(
  parameter  int REG_WIDTH = 8,
  parameter  int REG_COUNT = 8,
  localparam int IDX_W     = $clog2(REG_WIDTH),
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [IDX_W-1:0]     shamt,
  input  logic [1:0]           shift_mode,
  input  logic                 wb_en,
  input  logic                 wb_bit,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     bit_index,
  output logic                 rs1_bit,
  output logic                 rs2_bit,
  input  logic                 par_we,
  input  logic [ADDR_W-1:0]    par_addr,
  input  logic [REG_WIDTH-1:0] par_wdata,
  output logic [REG_WIDTH-1:0] par_rdata
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   last;

  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_WIDTH-1:0] shadow;
  logic [REG_WIDTH-1:0] commit_word;
  logic [ADDR_W-1:0]    rs1_lat;
  logic [ADDR_W-1:0]    rs2_lat;
  logic [ADDR_W-1:0]    rd_lat;
  logic [IDX_W-1:0]     shamt_lat;
  logic [1:0]           mode_lat;
  logic                 wb_en_lat;
  logic                 sel_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_index == IDX_W'(REG_WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // The final bit is written to shadow at the same edge as the commit, so splice it in.
  always_comb begin
    commit_word            = shadow;
    commit_word[bit_index] = wb_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_index <= '0;
      shadow    <= '0;
      rs1_lat   <= '0;
      rs2_lat   <= '0;
      rd_lat    <= '0;
      shamt_lat <= '0;
      mode_lat  <= MODE_DIRECT;
      wb_en_lat <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        rs1_lat   <= rs1_addr;
        rs2_lat   <= rs2_addr;
        rd_lat    <= rd_addr;
        shamt_lat <= shamt;
        mode_lat  <= shift_mode;
        wb_en_lat <= wb_en;
        bit_index <= '0;
      end
      if (busy) begin
        shadow[bit_index] <= wb_bit;
        bit_index         <= bit_index + IDX_W'(1);
        if (last && wb_en_lat && (rd_lat != '0)) regs[rd_lat] <= commit_word;
      end
      // Register 0 is never written, so it reads 0 forever.
      if (par_we && !busy && (par_addr != '0)) regs[par_addr] <= par_wdata;
    end
  end

  serial_bit_select #(
    .REG_WIDTH(REG_WIDTH)
  ) u_rs1_select (
    .word   (regs[rs1_lat]),
    .index  (bit_index),
    .shamt  (shamt_lat),
    .mode   (mode_lat),
    .sel_bit(sel_bit)
  );

  assign rs1_bit   = busy & sel_bit;
  assign rs2_bit   = busy & regs[rs2_lat][bit_index];
  assign par_rdata = regs[par_addr];

endmodule

// File: tb/tb_regfile_serial_multi.sv
// Bench for regfile_serial_multi: an 8x8 and a 16x4 instance against a word-level model.
module tb_regfile_serial_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        wide;
  logic        start, par_we, wb_en, wb_bit;
  logic [2:0]  rs1_addr, rs2_addr, rd_addr, par_addr;
  logic [3:0]  shamt;
  logic [1:0]  shift_mode;
  logic [15:0] par_wdata;

  logic        busy8, done8, rs1b8, rs2b8;
  logic [2:0]  bidx8;
  logic [7:0]  prd8;
  logic        busy16, done16, rs1b16, rs2b16;
  logic [3:0]  bidx16;
  logic [15:0] prd16;

  logic        busy_o, done_o, rs1_o, rs2_o;
  logic [3:0]  bidx_o;
  logic [15:0] prd_o;

  logic [15:0] mdl [2][8];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_serial_multi #(.REG_WIDTH(8), .REG_COUNT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start & ~wide),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .shamt(shamt[2:0]), .shift_mode(shift_mode), .wb_en(wb_en), .wb_bit(wb_bit),
    .busy(busy8), .done(done8), .bit_index(bidx8), .rs1_bit(rs1b8), .rs2_bit(rs2b8),
    .par_we(par_we & ~wide), .par_addr(par_addr), .par_wdata(par_wdata[7:0]),
    .par_rdata(prd8)
  );

  regfile_serial_multi #(.REG_WIDTH(16), .REG_COUNT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start & wide),
    .rs1_addr(rs1_addr[1:0]), .rs2_addr(rs2_addr[1:0]), .rd_addr(rd_addr[1:0]),
    .shamt(shamt), .shift_mode(shift_mode), .wb_en(wb_en), .wb_bit(wb_bit),
    .busy(busy16), .done(done16), .bit_index(bidx16), .rs1_bit(rs1b16), .rs2_bit(rs2b16),
    .par_we(par_we & wide), .par_addr(par_addr[1:0]), .par_wdata(par_wdata),
    .par_rdata(prd16)
  );

  assign busy_o = wide ? busy16 : busy8;
  assign done_o = wide ? done16 : done8;
  assign rs1_o  = wide ? rs1b16 : rs1b8;
  assign rs2_o  = wide ? rs2b16 : rs2b8;
  assign bidx_o = wide ? bidx16 : {1'b0, bidx8};
  assign prd_o  = wide ? prd16  : {8'h00, prd8};

  function automatic int width_now();
    return wide ? 16 : 8;
  endfunction

  function automatic int count_now();
    return wide ? 4 : 8;
  endfunction

  function automatic logic [15:0] mask_now();
    return wide ? 16'hFFFF : 16'h00FF;
  endfunction

  // Whole-word result of the rs1 view, from plain shift arithmetic.
  function automatic logic [15:0] shift_ref(logic [15:0] src, int sh, logic [1:0] md, int w);
    int mask = (1 << w) - 1;
    int s = int'(src);
    int r;
    case (md)
      2'b00:   r = s;
      2'b01:   r = (s << sh) & mask;
      2'b10:   r = s >> sh;
      default: begin
        r = s >> sh;
        if (((s >> (w - 1)) & 1) == 1) r = r | (mask & ~(mask >> sh));
      end
    endcase
    return 16'(r);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < count_now(); a++) begin
      par_addr = 3'(a);
      #1;
      chk(tag, prd_o, mdl[wide][a]);
    end
  endtask

  task automatic par_write(input logic [2:0] a, input logic [15:0] d);
    par_we = 1'b1; par_addr = a; par_wdata = d;
    step();
    par_we = 1'b0;
    if (a != 3'd0) mdl[wide][a] = d & mask_now();
  endtask

  task automatic read_const(input string tag, input logic [2:0] a, input logic [15:0] exp);
    par_addr = a;
    #1;
    chk(tag, prd_o, exp);
  endtask

  // One serial operation, starting and ending at a negedge in IDLE.
  task automatic run_op(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] ad,
                        input int sh, input logic [1:0] md, input logic we,
                        input logic loopb, input logic [15:0] pat,
                        input logic disturb, input logic pw, input logic [15:0] pwd);
    int w = width_now();
    logic [15:0] src, expv, r2, res;
    rs1_addr = a1; rs2_addr = a2; rd_addr = ad; shamt = 4'(sh);
    shift_mode = md; wb_en = we; start = 1'b1;
    if (pw) begin
      par_we = 1'b1; par_addr = a1; par_wdata = pwd;
      if (a1 != 3'd0) mdl[wide][a1] = pwd & mask_now();
    end
    src  = mdl[wide][a1];
    r2   = mdl[wide][a2];
    expv = shift_ref(src, sh, md, w);
    step();
    start = 1'b0; par_we = 1'b0;
    for (int i = 0; i < w; i++) begin
      chk("busy_shift", {15'd0, busy_o}, 16'd1);
      chk("done_shift", {15'd0, done_o}, 16'd0);
      chk("bit_index", {12'd0, bidx_o}, 16'(i));
      chk("rs1_bit", {15'd0, rs1_o}, {15'd0, expv[i]});
      chk("rs2_bit", {15'd0, rs2_o}, {15'd0, r2[i]});
      wb_bit = loopb ? rs1_o : pat[i];
      if (disturb && i == 3) begin
        par_we = 1'b1; par_addr = 3'd3; par_wdata = 16'h0055; start = 1'b1;
        rs1_addr = a1 ^ 3'd1; rd_addr = ad ^ 3'd1; shift_mode = ~md;
        shamt = 4'(sh + 1); wb_en = ~we;
      end
      if (disturb && i == 4) begin
        par_we = 1'b0; start = 1'b0;
      end
      if (i == w - 1) par_addr = ad;
      step();
    end
    res = loopb ? expv : (pat & mask_now());
    if (we && ad != 3'd0) mdl[wide][ad] = res;
    chk("done_pulse", {15'd0, done_o}, 16'd1);
    chk("busy_done", {15'd0, busy_o}, 16'd0);
    chk("rs1_idle", {15'd0, rs1_o}, 16'd0);
    chk("rs2_idle", {15'd0, rs2_o}, 16'd0);
    chk("commit", prd_o, mdl[wide][ad]);
    step();
    chk("done_once", {15'd0, done_o}, 16'd0);
    if (disturb) read_const("r3_kept", 3'd3, mdl[wide][3]);
  endtask

  task automatic random_ops(input int n);
    for (int k = 0; k < n; k++) begin
      logic [2:0] a1, a2, ad;
      a1 = 3'($urandom_range(count_now() - 1));
      a2 = 3'($urandom_range(count_now() - 1));
      ad = 3'($urandom_range(count_now() - 1));
      if ($urandom_range(1) == 1) par_write(3'($urandom_range(count_now() - 1)), 16'($urandom));
      run_op(a1, a2, ad, $urandom_range(width_now() - 1), 2'($urandom_range(3)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom),
             1'b0, 1'($urandom_range(1)), 16'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; wide = 1'b0; start = 1'b0; par_we = 1'b0; wb_en = 1'b0; wb_bit = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; par_addr = '0; shamt = '0;
    shift_mode = 2'b00; par_wdata = '0;
    for (int m = 0; m < 2; m++) for (int a = 0; a < 8; a++) mdl[m][a] = '0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {15'd0, busy_o}, 16'd0);
    chk("reset_done", {15'd0, done_o}, 16'd0);
    read_all("reset_regs8");
    wide = 1'b1;
    read_all("reset_regs16");
    chk("reset_busy16", {15'd0, busy_o}, 16'd0);
    wide = 1'b0;

    par_write(3'd1, 16'h00B4);
    run_op(3'd1, 3'd3, 3'd2, 2, 2'b01, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("sll_r2", 3'd2, 16'h00D0);
    run_op(3'd1, 3'd2, 3'd1, 3, 2'b11, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("sra_inplace", 3'd1, 16'h00F6);
    par_write(3'd1, 16'h00B4);
    run_op(3'd1, 3'd2, 3'd4, 3, 2'b10, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("srl_r4", 3'd4, 16'h0016);

    par_write(3'd0, 16'h00FF);
    read_const("r0_par", 3'd0, 16'h0000);
    run_op(3'd1, 3'd0, 3'd0, 0, 2'b00, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("r0_serial", 3'd0, 16'h0000);

    run_op(3'd1, 3'd5, 3'd6, 2, 2'b10, 1'b1, 1'b0, 16'h00A7, 1'b1, 1'b0, 16'h0);
    read_const("disturb_r6", 3'd6, 16'h00A7);
    read_const("disturb_r3", 3'd3, 16'h0000);
    run_op(3'd1, 3'd2, 3'd5, 1, 2'b01, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 16'h0);
    read_const("no_wb_r5", 3'd5, 16'h0000);
    run_op(3'd7, 3'd7, 3'd6, 1, 2'b01, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1, 16'h003C);
    read_const("same_edge_r6", 3'd6, 16'h0078);

    random_ops(24);
    read_all("rand_regs8");

    // Reset landing mid-operation.
    par_write(3'd2, 16'h005A);
    rs1_addr = 3'd2; rs2_addr = 3'd2; rd_addr = 3'd3; shamt = '0;
    shift_mode = 2'b00; wb_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_index", {12'd0, bidx_o}, 16'd4);
    rst = 1'b1;
    #1;
    chk("rst_busy", {15'd0, busy_o}, 16'd0);
    chk("rst_index", {12'd0, bidx_o}, 16'd0);
    for (int a = 0; a < 8; a++) mdl[0][a] = '0;
    read_all("rst_regs");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_no_done", {15'd0, done_o}, 16'd0);
    end
    read_all("rst_regs_after");

    wide = 1'b1;
    par_write(3'd1, 16'h8001);
    run_op(3'd1, 3'd0, 3'd1, 15, 2'b11, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("w16_sra", 3'd1, 16'hFFFF);
    par_write(3'd1, 16'h8001);
    run_op(3'd1, 3'd1, 3'd2, 15, 2'b01, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
    read_const("w16_sll", 3'd2, 16'h8000);
    random_ops(12);
    read_all("rand_regs16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
